// File: rtl/buffer_reader_pkg.sv
// Shared types and constants for the LPC ring-buffer reader.
package buffer_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StSend,
    StDone,
    StSettle
  } state_e;

  localparam logic [7:0]  TERM_BYTE     = 8'h0A;
  localparam logic [7:0]  OVF_TERM_BYTE = 8'h21;
  localparam int unsigned RAM_LATENCY   = 1;

endpackage

// File: rtl/buffer_reader_frame_serializer.sv
// Serializes one captured entry MSB-first plus a terminator onto a valid/ready byte stream.
// With BUFFER_READER_OVF_MARK_EN defined, a sticky overflow flag swaps the terminator to 0x21.
module frame_serializer
  import buffer_reader_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic                    overflow,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    frame_done
);

  localparam int unsigned     CntW    = $clog2(DATA_BYTES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_BYTES);

  logic [8*DATA_BYTES-1:0] shreg_q;
  logic [CntW-1:0]         cnt_q;
  logic                    active_q;
  logic [7:0]              term;
  logic                    accept;
  logic                    last;

  assign accept     = active_q & tx_ready;
  assign last       = (cnt_q == LastCnt);
  assign frame_done = accept & last;
  assign tx_valid   = active_q;
  assign tx_data    = !active_q ? 8'h00 : (last ? term : shreg_q[8*DATA_BYTES-1 -: 8]);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      shreg_q  <= data;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (accept) begin
      if (last) begin
        active_q <= 1'b0;
      end else begin
        shreg_q <= shreg_q << 8;
        cnt_q   <= cnt_q + CntW'(1);
      end
    end
  end

`ifdef BUFFER_READER_OVF_MARK_EN
  logic       flag_q;
  logic [7:0] term_q;

  // Terminator is chosen when the last data byte is accepted and then held stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q <= 1'b0;
      term_q <= TERM_BYTE;
    end else begin
      if (accept && !last && (cnt_q == LastCnt - CntW'(1))) begin
        term_q <= flag_q ? OVF_TERM_BYTE : TERM_BYTE;
      end
      if (overflow) begin
        flag_q <= 1'b1;
      end else if (frame_done && (term_q == OVF_TERM_BYTE)) begin
        flag_q <= 1'b0;
      end
    end
  end

  assign term = term_q;
`else
  logic unused_overflow;

  assign unused_overflow = overflow;
  assign term            = TERM_BYTE;
`endif

endmodule

// File: rtl/buffer_reader.sv
// Drains LPC entries from a ring buffer RAM and streams each as a terminated UART frame.
// Optional overflow marking is enabled by defining BUFFER_READER_OVF_MARK_EN.
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int unsigned BITS       = 5,
  parameter int unsigned DATA_BYTES = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    empty,
  input  logic                    overflow,
  output logic                    ram_rd_en,
  input  logic [8*DATA_BYTES-1:0] ram_data,
  output logic                    read_done,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [15:0]             frames_sent,
  output logic                    busy
);

  localparam int unsigned          FetchCntW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [FetchCntW-1:0] FetchLast = FetchCntW'(RAM_LATENCY - 1);

  state_e               state_q;
  logic [FetchCntW-1:0] fetch_cnt_q;
  logic                 ram_rd_en_q;
  logic                 read_done_q;
  logic [15:0]          frames_sent_q;
  logic                 busy_q;
  logic                 load;
  logic                 frame_done;

  // Pointer width belongs to the ring buffer itself; the reader only sees empty/overflow.
  logic [BITS-1:0] unused_bits;
  assign unused_bits = '0;

  assign load        = (state_q == StLoad);
  assign ram_rd_en   = ram_rd_en_q;
  assign read_done   = read_done_q;
  assign frames_sent = frames_sent_q;
  assign busy        = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fetch_cnt_q   <= '0;
      ram_rd_en_q   <= 1'b0;
      read_done_q   <= 1'b0;
      frames_sent_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      ram_rd_en_q <= 1'b0;
      read_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q     <= StFetch;
            fetch_cnt_q <= '0;
            ram_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StFetch: begin
          if (fetch_cnt_q == FetchLast) begin
            state_q <= StLoad;
          end else begin
            fetch_cnt_q <= fetch_cnt_q + FetchCntW'(1);
          end
        end
        StLoad: state_q <= StSend;
        StSend: begin
          if (frame_done) begin
            state_q     <= StDone;
            read_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q       <= StSettle;
          frames_sent_q <= frames_sent_q + 16'd1;
        end
        // Empty is ignored here so the pointer advance from read_done has landed.
        StSettle: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  frame_serializer #(
    .DATA_BYTES(DATA_BYTES)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data      (ram_data),
    .overflow  (overflow),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .frame_done(frame_done)
  );

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 SHALL have parameter BITS, default 5, ring buffer address width.
REQ-002 SHALL have parameter DATA_BYTES, default 6, bytes per captured LPC entry.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port empty, input, 1, ring buffer holds no unread entry.
REQ-006 SHALL have port overflow, input, 1, ring buffer write side is blocked.
REQ-007 SHALL have port ram_rd_en, output, 1, one-cycle read strobe to the entry RAM.
REQ-008 SHALL have port ram_data, input, 8*DATA_BYTES, RAM entry; valid exactly 1 cycle after ram_rd_en.
REQ-009 SHALL have port read_done, output, 1, one-cycle pulse that advances the ring buffer read pointer.
REQ-010 SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-011 SHALL have port tx_valid, output, 1, tx_data holds a byte.
REQ-012 SHALL have port tx_ready, input, 1, UART accepts the byte this cycle.
REQ-013 SHALL have port frames_sent, output, 16, count of completed frames.
REQ-014 SHALL have port busy, output, 1, state is not IDLE.

Function
REQ-015 SHALL implement the states IDLE, FETCH, LOAD, SEND, DONE, and SETTLE.
- IDLE -> FETCH when empty=0; ram_rd_en=1 in that transition cycle only.
- FETCH -> LOAD after 1 cycle.
- LOAD: capture ram_data into a shift register, byte count=0 -> SEND.
- SEND -> DONE after the terminator byte is accepted.
- DONE -> SETTLE -> IDLE.
REQ-016 SHALL send each frame as DATA_BYTES data bytes, most significant byte first, then one terminator byte; the frame is DATA_BYTES+1 bytes.
REQ-017 SHALL accept a byte only when tx_valid=1 and tx_ready=1 in the same cycle.
REQ-018 SHALL keep tx_valid high and tx_data stable from assertion until acceptance; tx_valid SHALL be low outside SEND.
REQ-019 SHALL keep tx_valid high in the cycle after an accepted non-final byte, carrying the next byte, so back-to-back acceptance gives one byte per cycle.
REQ-020 SHALL use terminator 0x0A, except as stated in REQ-030.
REQ-021 SHALL assert read_done for exactly one cycle, in DONE only.
REQ-022 SHALL increment frames_sent in DONE, modulo 2^16 (0xFFFF -> 0x0000).
REQ-023 SHALL NOT sample empty in SETTLE; this guarantees the pointer update from read_done is visible before the next fetch.
REQ-024 SHALL give minimum frame latency, from empty falling to the first tx_valid, of 3 cycles (IDLE, FETCH, LOAD).
REQ-025 SHALL ignore overflow for control flow; draining continues regardless.
REQ-026 SHALL drop nothing and duplicate nothing: exactly one read_done per fully sent frame.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, force state IDLE, tx_valid=0, tx_data=0x00, ram_rd_en=0, read_done=0, frames_sent=0, busy=0, and clear the overflow flag.
REQ-028 SHALL, on reset during FETCH, LOAD or SEND, abandon the partial frame without a read_done pulse; the same entry is re-sent in full after reset.
REQ-029 SHALL give reset priority over every other event in the same cycle.

Configuration
REQ-030 SHALL, with macro BUFFER_READER_OVF_MARK_EN defined, behave as follows:
- A sticky flag sets in any cycle with overflow=1.
- Each frame whose terminator is loaded while the flag is set sends terminator 0x21 instead of 0x0A.
- The flag clears when that 0x21 is accepted, unless overflow=1 in the same cycle; set wins.
REQ-031 SHALL, without the macro, keep the overflow port present but unused, with no flag logic, and always send terminator 0x0A.

Structure
REQ-032 SHALL place in shared package buffer_reader_pkg: the state enum, TERM_BYTE=0x0A, OVF_TERM_BYTE=0x21 and RAM_LATENCY=1.
REQ-033 SHALL contain one sub-module, frame_serializer (shift register, byte counter, terminator mux, valid/ready logic), with the FSM and counters in buffer_reader.

Verification
REQ-034 SHALL cover single entry: empty falls with ram_data=0x112233445566, tx_ready=1 -> bytes 11 22 33 44 55 66 0A on 7 consecutive cycles, one read_done, frames_sent=1.
REQ-035 SHALL cover backpressure: tx_ready low for 5 cycles on byte 3 -> tx_data holds 0x33 with tx_valid=1 throughout, no byte lost or repeated.
REQ-036 SHALL cover back-to-back entries: empty stays 0 for 3 entries -> 3 frames, 3 read_done pulses each separated by at least 1 SETTLE cycle, frames_sent=3.
REQ-037 SHALL cover mid-frame reset: reset after byte 2 accepted -> tx_valid=0 next cycle, no read_done; after release the same entry is re-sent from byte 1.
REQ-038 SHALL cover the overflow mark with the macro defined: overflow pulsed 1 cycle during frame N -> frame N terminator 0x21, frame N+1 terminator 0x0A; without the macro both terminators are 0x0A.
REQ-039 SHALL cover counter wrap: frames_sent preloaded by forcing 65535 frames -> next frame gives frames_sent=0x0000.
